// File: rtl/selftest_pkg.sv
// Shared definitions for the CPU self-test sequencer: FSM state encoding,
// the reset hold length and a few MIPS register indices used by check tables.
package selftest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    CHECK,
    DONE
  } state_t;

  localparam int HOLD_CYCLES = 2;

  localparam logic [4:0] T0 = 5'd8;
  localparam logic [4:0] T1 = 5'd9;
  localparam logic [4:0] T2 = 5'd10;
  localparam logic [4:0] RA = 5'd31;

  // Index width that stays at least one bit wide for single-entry tables.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/selftest_checker.sv
// Register check accumulator for the self-test sequencer. While enabled it
// compares the debug read data with the expected value of the current check
// entry, counts mismatches and remembers the index of the first one.
module selftest_checker
  import selftest_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 2,
  parameter int CNT_W  = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic              i_chkValid,
  input  logic [CHK_W-1:0]  i_chkIdx,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_expected,
  output logic [CNT_W-1:0]  o_failCount,
  output logic [CHK_W-1:0]  o_firstFail
);

  logic             w_mismatch;
  logic [CNT_W-1:0] r_failCount;
  logic [CHK_W-1:0] r_firstFail;

  // A check entry only counts against the CPU when it is marked valid.
  always_comb begin
    w_mismatch = i_chkValid && (i_rdata != i_expected);
  end

  // Mismatch counter and first-mismatch index. Both are wiped when a new
  // sequence starts; the index is captured only while the count is still zero
  // so later mismatches never overwrite it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_failCount <= '0;
      r_firstFail <= '0;
    end else if (i_clear) begin
      r_failCount <= '0;
      r_firstFail <= '0;
    end else if (i_enable && w_mismatch) begin
      r_failCount <= r_failCount + 1'b1;
      if (r_failCount == '0) begin
        r_firstFail <= i_chkIdx;
      end
    end
  end

  assign o_failCount = r_failCount;
  assign o_firstFail = r_firstFail;

endmodule

// File: rtl/cpu_selftest_sequencer.sv
// On-chip CPU self-test sequencer. Loads a sparse program table into the CPU
// instruction memory, holds the CPU in reset briefly, runs it for a cycle
// budget, then walks a register check table through the debug read port.
// Optional build macro SELFTEST_HALT_DETECT_EN ends the run early once the
// CPU program counter stops moving, and reports that through 'halted'.
module cpu_selftest_sequencer
  import selftest_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int PROG_DEPTH = 16,
  parameter int NUM_CHECKS = 4,
  parameter int RUN_CYCLES = 20,
  parameter int REG_AW     = 5,
  localparam int PIDX_W    = idxWidth(PROG_DEPTH),
  localparam int CIDX_W    = idxWidth(NUM_CHECKS),
  localparam int CNT_W     = $clog2(NUM_CHECKS + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [PIDX_W-1:0] tbl_idx,
  input  logic              tbl_valid,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_instr,
  output logic [CIDX_W-1:0] chk_idx,
  input  logic              chk_valid,
  input  logic [REG_AW-1:0] chk_reg,
  input  logic [DATA_W-1:0] chk_expected,
  output logic              cpu_reset,
  output logic              imem_we,
  output logic [ADDR_W-3:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [REG_AW-1:0] dbg_raddr,
  input  logic [DATA_W-1:0] dbg_rdata,
`ifdef SELFTEST_HALT_DETECT_EN
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              halted,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_count,
  output logic [CIDX_W-1:0] first_fail
);

  localparam int CYC_W = idxWidth((RUN_CYCLES > HOLD_CYCLES) ? RUN_CYCLES : HOLD_CYCLES);

  state_t            r_state;
  logic [PIDX_W-1:0] r_tblIdx;
  logic [CIDX_W-1:0] r_chkIdx;
  logic [CYC_W-1:0]  r_cycCnt;
  logic              r_cpuReset;
  logic              r_busy;
  logic              r_done;

  logic              w_startAccept;
  logic              w_checkEnable;
  logic              w_budgetEnd;
  logic              w_haltNow;
  logic [CNT_W-1:0]  w_failCount;
  logic [CIDX_W-1:0] w_firstFail;

`ifdef SELFTEST_HALT_DETECT_EN
  logic [ADDR_W-1:0] r_prevPc;
  logic              r_pcSameLast;
  logic              r_halted;
  logic              w_pcSame;
`endif

  // Start is only honoured when no sequence is in flight; run-end is the
  // budget expiry or, in the halt-detect build, two back-to-back RUN cycles in
  // which the program counter did not move (the program reached its self-loop).
  always_comb begin
    w_startAccept = start && ((r_state == IDLE) || (r_state == DONE));
    w_checkEnable = (r_state == CHECK);
    w_budgetEnd   = (r_cycCnt == CYC_W'(RUN_CYCLES - 1));
`ifdef SELFTEST_HALT_DETECT_EN
    w_pcSame      = (r_cycCnt != '0) && (cpu_pc == r_prevPc);
    w_haltNow     = w_pcSame && r_pcSameLast;
`else
    w_haltNow     = 1'b0;
`endif
  end

  // Sequencer FSM. Outputs are registered alongside the state so cpu_reset
  // drops on the very edge that enters RUN and stays low through CHECK and
  // DONE, letting the CPU free-run on its final self-jump while registers
  // are read back.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_tblIdx   <= '0;
      r_chkIdx   <= '0;
      r_cycCnt   <= '0;
      r_cpuReset <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef SELFTEST_HALT_DETECT_EN
      r_prevPc     <= '0;
      r_pcSameLast <= 1'b0;
      r_halted     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_startAccept) begin
            r_state    <= LOAD;
            r_tblIdx   <= '0;
            r_cpuReset <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
`ifdef SELFTEST_HALT_DETECT_EN
            r_halted   <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (r_tblIdx == PIDX_W'(PROG_DEPTH - 1)) begin
            r_state  <= HOLD;
            r_tblIdx <= '0;
            r_cycCnt <= '0;
          end else begin
            r_tblIdx <= r_tblIdx + 1'b1;
          end
        end
        HOLD: begin
          if (r_cycCnt == CYC_W'(HOLD_CYCLES - 1)) begin
            r_state    <= RUN;
            r_cycCnt   <= '0;
            r_cpuReset <= 1'b0;
`ifdef SELFTEST_HALT_DETECT_EN
            r_pcSameLast <= 1'b0;
`endif
          end else begin
            r_cycCnt <= r_cycCnt + 1'b1;
          end
        end
        RUN: begin
`ifdef SELFTEST_HALT_DETECT_EN
          r_prevPc     <= cpu_pc;
          r_pcSameLast <= w_pcSame;
`endif
          if (w_budgetEnd || w_haltNow) begin
            r_state  <= CHECK;
            r_chkIdx <= '0;
            r_cycCnt <= '0;
`ifdef SELFTEST_HALT_DETECT_EN
            r_halted <= w_haltNow;
`endif
          end else begin
            r_cycCnt <= r_cycCnt + 1'b1;
          end
        end
        CHECK: begin
          if (r_chkIdx == CIDX_W'(NUM_CHECKS - 1)) begin
            r_state  <= DONE;
            r_chkIdx <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_chkIdx <= r_chkIdx + 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_cpuReset <= 1'b1;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  selftest_checker #(
    .DATA_W (DATA_W),
    .CHK_W  (CIDX_W),
    .CNT_W  (CNT_W)
  ) u_checker (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_clear     (w_startAccept),
    .i_enable    (w_checkEnable),
    .i_chkValid  (chk_valid),
    .i_chkIdx    (r_chkIdx),
    .i_rdata     (dbg_rdata),
    .i_expected  (chk_expected),
    .o_failCount (w_failCount),
    .o_firstFail (w_firstFail)
  );

  assign tbl_idx    = r_tblIdx;
  assign chk_idx    = r_chkIdx;
  assign imem_we    = (r_state == LOAD) && tbl_valid;
  assign imem_waddr = tbl_addr[ADDR_W-1:2];
  assign imem_wdata = tbl_instr;
  assign dbg_raddr  = chk_reg;
  assign cpu_reset  = r_cpuReset;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_done && (w_failCount == '0);
  assign fail_count = w_failCount;
  assign first_fail = w_firstFail;
`ifdef SELFTEST_HALT_DETECT_EN
  assign halted     = r_halted && r_done;
`endif

endmodule
